// File: rtl/biriscv_muldiv_sched_pkg.sv
// Shared definitions for the mul/div unit scheduler: op codes, FSM state
// encoding and a helper that tells reserved ops apart from real unit ops.
package biriscv_defs;

    localparam logic [2:0] MULDIV_OP_DIV  = 3'd0;
    localparam logic [2:0] MULDIV_OP_DIVU = 3'd1;
    localparam logic [2:0] MULDIV_OP_REM  = 3'd2;
    localparam logic [2:0] MULDIV_OP_REMU = 3'd3;
    localparam logic [2:0] MULDIV_OP_MULE = 3'd4;
    localparam logic [2:0] MULDIV_OP_CBM  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } muldiv_state_e;

    // Codes above CBM never reach the unit; they complete with a zero result.
    function automatic logic is_reserved_op(input logic [2:0] op);
        return op > MULDIV_OP_CBM;
    endfunction

endpackage

// File: rtl/biriscv_muldiv_sched.sv
// Arbitrates the two issue slots onto the shared iterative div/custom unit,
// sequences start/abort/timeout and holds the result until writeback takes it.
module biriscv_muldiv_sched
    import biriscv_defs::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    input  logic [2:0]  req0_op_i,
    input  logic [31:0] req0_ra_i,
    input  logic [31:0] req0_rb_i,
    input  logic [4:0]  req0_rd_i,
    input  logic        req1_valid_i,
    input  logic [2:0]  req1_op_i,
    input  logic [31:0] req1_ra_i,
    input  logic [31:0] req1_rb_i,
    input  logic [4:0]  req1_rd_i,
    output logic        req0_accept_o,
    output logic        req1_accept_o,
    output logic        unit_start_o,
    output logic [2:0]  unit_op_o,
    output logic [31:0] unit_ra_o,
    output logic [31:0] unit_rb_o,
    output logic        unit_abort_o,
    input  logic        unit_done_i,
    input  logic [31:0] unit_result_i,
    input  logic        flush_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_value_o,
    input  logic        wb_ready_i,
    output logic        busy_o,
    output logic [4:0]  busy_rd_o,
    output logic        timeout_o
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

    muldiv_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [31:0]       ra_q, ra_d;
    logic [31:0]       rb_q, rb_d;
    logic [4:0]        rd_q, rd_d;
    logic [31:0]       value_q, value_d;
    logic              start_q, start_d;
    logic              abort_q, abort_d;
    logic              timeout_q, timeout_d;
    logic              accept0, accept1;
    logic [2:0]        sel_op;

    assign sel_op = accept0 ? req0_op_i : req1_op_i;

    // NOTE: every signal driven here gets a default first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        rd_d      = rd_q;
        value_d   = value_q;
        start_d   = 1'b0;
        abort_d   = 1'b0;
        timeout_d = 1'b0;
        accept0   = 1'b0;
        accept1   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                accept0 = req0_valid_i & ~flush_i;
                accept1 = req1_valid_i & ~req0_valid_i & ~flush_i;
                if (accept0 || accept1) begin
                    op_d    = sel_op;
                    ra_d    = accept0 ? req0_ra_i : req1_ra_i;
                    rb_d    = accept0 ? req0_rb_i : req1_rb_i;
                    rd_d    = accept0 ? req0_rd_i : req1_rd_i;
                    value_d = '0;
                    cnt_d   = '0;
                    if (is_reserved_op(sel_op)) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_RUN;
                        start_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                // The first RUN cycle carries the start pulse, so done is not trusted yet.
                if ((cnt_q != '0) && unit_done_i) begin
                    value_d = unit_result_i;
                    state_d = ST_HOLD;
                end else if (cnt_d == TIMEOUT_CNT) begin
                    value_d   = 32'hFFFF_FFFF;
                    abort_d   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (wb_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush_i) begin
            state_d   = ST_IDLE;
            value_d   = value_q;
            abort_d   = (state_q == ST_RUN);
            timeout_d = 1'b0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge value of the others, matching the hardware.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: latched payload is reset too, because these registers feed
            // outputs directly and must read 0 straight out of reset.
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            rd_q      <= '0;
            value_q   <= '0;
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            rd_q      <= rd_d;
            value_q   <= value_d;
            start_q   <= start_d;
            abort_q   <= abort_d;
            timeout_q <= timeout_d;
        end
    end

    assign req0_accept_o = accept0;
    assign req1_accept_o = accept1;
    assign unit_start_o  = start_q;
    assign unit_op_o     = op_q;
    assign unit_ra_o     = ra_q;
    assign unit_rb_o     = rb_q;
    assign unit_abort_o  = abort_q;
    assign timeout_o     = timeout_q;
    assign wb_valid_o    = (state_q == ST_HOLD);
    assign wb_rd_o       = rd_q;
    assign wb_value_o    = value_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign busy_rd_o     = (state_q != ST_IDLE) ? rd_q : 5'd0;

endmodule

// File: tb/tb_biriscv_muldiv_sched.sv
// Randomized and directed bench for biriscv_muldiv_sched, checked every cycle
// against a transaction-level model of the scheduler.
module tb_biriscv_muldiv_sched;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] req0_ra, req0_rb, req1_ra, req1_rb;
    logic [4:0]  req0_rd, req1_rd;
    logic        req0_accept, req1_accept;
    logic        unit_start, unit_abort, unit_done;
    logic [2:0]  unit_op;
    logic [31:0] unit_ra, unit_rb, unit_result;
    logic        flush, wb_valid, wb_ready, busy, timeout;
    logic [4:0]  wb_rd, busy_rd;
    logic [31:0] wb_value;

    int checks   = 0;
    int failures = 0;
    bit skip_chk = 1'b1;

    // Model: one transaction record that is either waiting on the unit or
    // holding its result, plus the pulses due in the next cycle.
    bit          m_run, m_hold, m_start, m_abort, m_timeout;
    int          m_age;
    logic [2:0]  m_op;
    logic [31:0] m_ra, m_rb, m_value;
    logic [4:0]  m_rd;

    always #5 clk = ~clk;

    biriscv_muldiv_sched #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(7)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(req0_valid), .req0_op_i(req0_op), .req0_ra_i(req0_ra),
        .req0_rb_i(req0_rb), .req0_rd_i(req0_rd),
        .req1_valid_i(req1_valid), .req1_op_i(req1_op), .req1_ra_i(req1_ra),
        .req1_rb_i(req1_rb), .req1_rd_i(req1_rd),
        .req0_accept_o(req0_accept), .req1_accept_o(req1_accept),
        .unit_start_o(unit_start), .unit_op_o(unit_op), .unit_ra_o(unit_ra),
        .unit_rb_o(unit_rb), .unit_abort_o(unit_abort),
        .unit_done_i(unit_done), .unit_result_i(unit_result),
        .flush_i(flush), .wb_valid_o(wb_valid), .wb_rd_o(wb_rd),
        .wb_value_o(wb_value), .wb_ready_i(wb_ready),
        .busy_o(busy), .busy_rd_o(busy_rd), .timeout_o(timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    task automatic quiet_inputs();
        req0_valid = 0; req1_valid = 0; flush = 0; unit_done = 0; wb_ready = 0;
        unit_result = '0;
    endtask

    task automatic model_reset();
        m_run = 0; m_hold = 0; m_start = 0; m_abort = 0; m_timeout = 0;
        m_age = 0; m_op = '0; m_ra = '0; m_rb = '0; m_rd = '0; m_value = '0;
    endtask

    // One clock: compare outputs mid-cycle, advance the model, cross the edge.
    task automatic cycle();
        bit idle, exp0, exp1, ns, na, nt;
        @(negedge clk);
        idle = !m_run && !m_hold;
        exp0 = idle && req0_valid && !flush;
        exp1 = idle && req1_valid && !req0_valid && !flush;
        if (!skip_chk) begin
            check("req0_accept", 32'(req0_accept), 32'(exp0));
            check("req1_accept", 32'(req1_accept), 32'(exp1));
            check("unit_start",  32'(unit_start),  32'(m_start));
            check("unit_abort",  32'(unit_abort),  32'(m_abort));
            check("timeout",     32'(timeout),     32'(m_timeout));
            check("wb_valid",    32'(wb_valid),    32'(m_hold));
            check("wb_rd",       32'(wb_rd),       32'(m_rd));
            check("wb_value",    wb_value,         m_value);
            check("busy",        32'(busy),        32'(m_run || m_hold));
            check("busy_rd",     32'(busy_rd),     (m_run || m_hold) ? 32'(m_rd) : 32'd0);
            check("unit_op",     32'(unit_op),     32'(m_op));
            check("unit_ra",     unit_ra,          m_ra);
            check("unit_rb",     unit_rb,          m_rb);
        end
        ns = 0; na = 0; nt = 0;
        if (rst) begin
            model_reset();
        end else begin
            if (flush) begin
                na = m_run;
                m_run = 0; m_hold = 0;
            end else if (exp0 || exp1) begin
                m_op    = exp0 ? req0_op : req1_op;
                m_ra    = exp0 ? req0_ra : req1_ra;
                m_rb    = exp0 ? req0_rb : req1_rb;
                m_rd    = exp0 ? req0_rd : req1_rd;
                m_value = '0;
                if (m_op >= 3'd6) m_hold = 1;
                else begin m_run = 1; m_age = 0; ns = 1; end
            end else if (m_run) begin
                m_age++;
                if (m_age >= 2 && unit_done) begin
                    m_value = unit_result; m_run = 0; m_hold = 1;
                end else if (m_age == TIMEOUT) begin
                    m_value = 32'hFFFF_FFFF; m_run = 0; m_hold = 1; na = 1; nt = 1;
                end
            end else if (m_hold && wb_ready) begin
                m_hold = 0;
            end
            m_start = ns; m_abort = na; m_timeout = nt;
        end
        @(posedge clk);
        #1;
        skip_chk = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic set_req0(input logic [2:0] op, input logic [31:0] ra, input logic [31:0] rb, input logic [4:0] rd);
        req0_valid = 1; req0_op = op; req0_ra = ra; req0_rb = rb; req0_rd = rd;
    endtask

    task automatic set_req1(input logic [2:0] op, input logic [31:0] ra, input logic [31:0] rb, input logic [4:0] rd);
        req1_valid = 1; req1_op = op; req1_ra = ra; req1_rb = rb; req1_rd = rd;
    endtask

    initial begin
        model_reset();
        quiet_inputs();
        req0_op = '0; req0_ra = '0; req0_rb = '0; req0_rd = '0;
        req1_op = '0; req1_ra = '0; req1_rb = '0; req1_rd = '0;
        rst = 1;
        cycle();
        cycle();
        rst = 0;
        cycle();

        // DIV 100/7 to rd 5, unit answers 4 cycles after start, wb stalled 3 cycles.
        set_req0(3'd0, 32'd100, 32'd7, 5'd5);
        cycle();
        req0_valid = 0;
        cycles(4);
        unit_done = 1; unit_result = 32'd14;
        cycle();
        unit_done = 0;
        cycles(3);
        wb_ready = 1;
        cycle();
        wb_ready = 0;
        cycle();

        // Both slots valid: slot 0 first, slot 1 right after slot 0's handshake.
        set_req0(3'd1, 32'd50, 32'd3, 5'd9);
        set_req1(3'd2, 32'd77, 32'd10, 5'd12);
        cycle();
        req0_valid = 0;
        cycles(2);
        unit_done = 1; unit_result = 32'd16;
        cycle();
        unit_done = 0; wb_ready = 1;
        cycle();
        wb_ready = 0;
        cycle();
        req1_valid = 0;
        cycles(2);
        unit_done = 1; unit_result = 32'd7;
        cycle();
        unit_done = 0; wb_ready = 1;
        cycle();
        wb_ready = 0;

        // Flush at the third RUN cycle, with a simultaneous done that must be dropped.
        set_req0(3'd4, 32'h1234, 32'h5678, 5'd3);
        cycle();
        req0_valid = 0;
        cycles(2);
        flush = 1; unit_done = 1; unit_result = 32'hDEAD_BEEF;
        cycle();
        flush = 0; unit_done = 0;
        cycles(2);

        // Unit never answers: forced abort and all-ones result.
        set_req1(3'd5, 32'hAAAA_5555, 32'h0F0F_F0F0, 5'd31);
        cycle();
        req1_valid = 0;
        cycles(TIMEOUT + 3);
        wb_ready = 1;
        cycle();
        wb_ready = 0;

        // Reserved op from slot 1 completes without touching the unit.
        set_req1(3'd7, 32'd1, 32'd2, 5'd17);
        cycle();
        req1_valid = 0;
        cycle();
        wb_ready = 1;
        cycle();
        wb_ready = 0;

        // One-cycle reset mid-RUN, then a fresh request accepted immediately.
        set_req0(3'd3, 32'd99, 32'd4, 5'd21);
        cycle();
        req0_valid = 0;
        cycles(3);
        rst = 1;
        cycle();
        rst = 0;
        set_req0(3'd0, 32'd8, 32'd2, 5'd1);
        cycle();
        req0_valid = 0;
        cycles(2);
        unit_done = 1; unit_result = 32'd4;
        cycle();
        unit_done = 0; wb_ready = 1;
        cycle();
        wb_ready = 0;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            req0_valid  = ($urandom_range(0, 1) == 1);
            req1_valid  = ($urandom_range(0, 1) == 1);
            req0_op     = 3'($urandom_range(0, 7));
            req1_op     = 3'($urandom_range(0, 7));
            req0_ra     = $urandom; req0_rb = $urandom; req0_rd = 5'($urandom);
            req1_ra     = $urandom; req1_rb = $urandom; req1_rd = 5'($urandom);
            flush       = ($urandom_range(0, 15) == 0);
            unit_done   = ($urandom_range(0, 4) == 0);
            unit_result = $urandom;
            wb_ready    = ($urandom_range(0, 2) == 0);
            rst         = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 0;
        quiet_inputs();
        cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
